// File: rtl/blend_fx_pkg.sv
// Shared encodings and saturation limits for the blend effect sequencer.
package blend_fx_pkg;

   localparam int unsigned PIX_W  = 4;
   localparam int unsigned RATE_W = 4;
   localparam int unsigned FRM_W  = 5;

   localparam logic [PIX_W-1:0] SAT_MAX = 4'hF;
   localparam logic [PIX_W-1:0] SAT_MIN = 4'h0;

   typedef enum logic [1:0] {
      CMD_NOP      = 2'd0,
      CMD_FADE_OUT = 2'd1,
      CMD_FADE_IN  = 2'd2,
      CMD_FLASH    = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_FADE_IN  = 2'd2,
      ST_FLASH    = 2'd3
   } state_e;

endpackage

// File: rtl/blend_fx_fsm.sv
// Frame-stepped effect controller: owns the fade amount, rate and frame counters.
module blend_fx_fsm
   import blend_fx_pkg::*;
#(
   parameter int unsigned FADE_RATE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vblank,
   input  logic             cmd_wr,
   input  logic [1:0]       cmd,
   input  logic [3:0]       cmd_arg,
   output logic [PIX_W-1:0] fade_level,
   output logic             busy,
   output logic             flash
);

   localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(FADE_RATE - 1);

   state_e            state;
   logic              vblank_q;
   logic              tick;
   logic [RATE_W-1:0] rate_cnt;
   logic [FRM_W-1:0]  frame_cnt;

   // Frame tick on VBLANK rising edge.
   assign tick = vblank & ~vblank_q;

   // Effect state machine; a command always wins over a coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         fade_level <= SAT_MIN;
         rate_cnt   <= '0;
         frame_cnt  <= '0;
         vblank_q   <= 1'b0;
         busy       <= 1'b0;
         flash      <= 1'b0;
      end else begin
         vblank_q <= vblank;
         if (cmd_wr) begin
            rate_cnt <= '0;
            case (cmd)
               CMD_FADE_OUT: begin
                  state <= ST_FADE_OUT;
                  busy  <= 1'b1;
                  flash <= 1'b0;
               end
               CMD_FADE_IN: begin
                  state <= ST_FADE_IN;
                  busy  <= 1'b1;
                  flash <= 1'b0;
               end
               CMD_FLASH: begin
                  state     <= ST_FLASH;
                  busy      <= 1'b1;
                  flash     <= 1'b1;
                  frame_cnt <= (cmd_arg == 4'd0) ? FRM_W'(16) : FRM_W'(cmd_arg);
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  flash <= 1'b0;
               end
            endcase
         end else if (tick) begin
            case (state)
               ST_FADE_OUT: begin
                  if (fade_level == SAT_MAX) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else if (rate_cnt == RATE_LAST) begin
                     rate_cnt   <= '0;
                     fade_level <= fade_level + 4'd1;
                     if (fade_level == SAT_MAX - 4'd1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     rate_cnt <= rate_cnt + 4'd1;
                  end
               end
               ST_FADE_IN: begin
                  if (fade_level == SAT_MIN) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else if (rate_cnt == RATE_LAST) begin
                     rate_cnt   <= '0;
                     fade_level <= fade_level - 4'd1;
                     if (fade_level == SAT_MIN + 4'd1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     rate_cnt <= rate_cnt + 4'd1;
                  end
               end
               ST_FLASH: begin
                  frame_cnt <= frame_cnt - 5'd1;
                  if (frame_cnt <= 5'd1) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     flash <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/blend_fx_sequencer.sv
// Per-channel blender driver: two-stage pixel pipeline around an external blender.
module blend_fx_sequencer
   import blend_fx_pkg::*;
#(
   parameter int unsigned FADE_RATE = 2
) (
   input  logic       i_EMU_MCLK,
   input  logic       i_RST,
   input  logic       i_PCEN,
   input  logic       i_HBLANK,
   input  logic       i_VBLANK,
   input  logic [3:0] i_TMPIXEL,
   input  logic [3:0] i_OBJPIXEL,
   input  logic       i_OBJVALID,
   input  logic       i_OBJTRANS,
   input  logic       i_CMD_WR,
   input  logic [1:0] i_CMD,
   input  logic [3:0] i_CMD_ARG,
   output logic [3:0] o_BLD_TMPIXEL,
   output logic [3:0] o_BLD_OBJPIXEL,
   output logic       o_BLD_TMEN,
   output logic       o_BLD_OUTEN,
   output logic       o_BLD_FORCEWHITE,
   output logic       o_BLD_MODE,
   input  logic [3:0] i_BLD_OUT,
   input  logic       i_BLD_CARRY,
   output logic [3:0] o_PIXEL,
   output logic [3:0] o_FADE_LEVEL,
   output logic       o_BUSY
);

   logic             flash;
   logic             obj_trans_hit;
   logic [PIX_W-1:0] base_pix;

   blend_fx_fsm #(
      .FADE_RATE (FADE_RATE)
   ) u_fsm (
      .clk        (i_EMU_MCLK),
      .rst        (i_RST),
      .vblank     (i_VBLANK),
      .cmd_wr     (i_CMD_WR),
      .cmd        (i_CMD),
      .cmd_arg    (i_CMD_ARG),
      .fade_level (o_FADE_LEVEL),
      .busy       (o_BUSY),
      .flash      (flash)
   );

   // Opaque object covers the tilemap; translucent object becomes the add operand.
   always_comb begin
      obj_trans_hit = i_OBJVALID & i_OBJTRANS;
      base_pix      = (i_OBJVALID & ~i_OBJTRANS) ? i_OBJPIXEL : i_TMPIXEL;
   end

   // Stage 1: select base/operand and blend mode for the blender.
   always_ff @(posedge i_EMU_MCLK) begin
      if (i_RST) begin
         o_BLD_TMPIXEL    <= SAT_MIN;
         o_BLD_OBJPIXEL   <= SAT_MIN;
         o_BLD_TMEN       <= 1'b0;
         o_BLD_OUTEN      <= 1'b0;
         o_BLD_FORCEWHITE <= 1'b0;
         o_BLD_MODE       <= 1'b0;
      end else if (i_PCEN) begin
         if (obj_trans_hit) begin
            o_BLD_TMPIXEL  <= i_TMPIXEL;
            o_BLD_OBJPIXEL <= i_OBJPIXEL;
            o_BLD_MODE     <= 1'b0;
         end else begin
            o_BLD_TMPIXEL  <= base_pix;
            o_BLD_OBJPIXEL <= ~o_FADE_LEVEL;
            o_BLD_MODE     <= 1'b1;
         end
         o_BLD_TMEN       <= 1'b1;
         o_BLD_OUTEN      <= ~(i_HBLANK | i_VBLANK);
         o_BLD_FORCEWHITE <= flash;
      end
   end

   // Stage 2: saturate the blender result; blanking beats force-white.
   always_ff @(posedge i_EMU_MCLK) begin
      if (i_RST) begin
         o_PIXEL <= SAT_MIN;
      end else if (i_PCEN) begin
         if (!o_BLD_OUTEN)
            o_PIXEL <= SAT_MIN;
         else if (o_BLD_FORCEWHITE)
            o_PIXEL <= SAT_MAX;
         else if (!o_BLD_MODE && i_BLD_CARRY)
            o_PIXEL <= SAT_MAX;
         else if (o_BLD_MODE && !i_BLD_CARRY)
            o_PIXEL <= SAT_MIN;
         else
            o_PIXEL <= i_BLD_OUT;
      end
   end

endmodule

// File: tb/tb_blend_fx_sequencer.sv
// Directed bench for blend_fx_sequencer with a behavioural blender model.
module tb_blend_fx_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pcen;
   logic       hblank;
   logic       vblank;
   logic [3:0] tm_pix;
   logic [3:0] obj_pix;
   logic       obj_valid;
   logic       obj_trans;
   logic       cmd_wr;
   logic [1:0] cmd;
   logic [3:0] cmd_arg;
   logic [3:0] bld_tm;
   logic [3:0] bld_obj;
   logic       bld_tmen;
   logic       bld_outen;
   logic       bld_fw;
   logic       bld_mode;
   logic [3:0] bld_out;
   logic       bld_carry;
   logic [3:0] pixel;
   logic [3:0] fade_level;
   logic       busy;
   logic [4:0] bsum;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Blender: add in mode 0, subtract with 2's-complement operand in mode 1.
   assign bsum      = 5'(bld_tm) + 5'(bld_obj) + 5'(bld_mode);
   assign bld_out   = bsum[3:0];
   assign bld_carry = bsum[4];

   blend_fx_sequencer #(
      .FADE_RATE (2)
   ) dut (
      .i_EMU_MCLK       (clk),
      .i_RST            (rst),
      .i_PCEN           (pcen),
      .i_HBLANK         (hblank),
      .i_VBLANK         (vblank),
      .i_TMPIXEL        (tm_pix),
      .i_OBJPIXEL       (obj_pix),
      .i_OBJVALID       (obj_valid),
      .i_OBJTRANS       (obj_trans),
      .i_CMD_WR         (cmd_wr),
      .i_CMD            (cmd),
      .i_CMD_ARG        (cmd_arg),
      .o_BLD_TMPIXEL    (bld_tm),
      .o_BLD_OBJPIXEL   (bld_obj),
      .o_BLD_TMEN       (bld_tmen),
      .o_BLD_OUTEN      (bld_outen),
      .o_BLD_FORCEWHITE (bld_fw),
      .o_BLD_MODE       (bld_mode),
      .i_BLD_OUT        (bld_out),
      .i_BLD_CARRY      (bld_carry),
      .o_PIXEL          (pixel),
      .o_FADE_LEVEL     (fade_level),
      .o_BUSY           (busy)
   );

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs === exp_v)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] c, input logic [3:0] a);
      cmd_wr  = 1'b1;
      cmd     = c;
      cmd_arg = a;
      step();
      cmd_wr  = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         vblank = 1'b1;
         step();
         vblank = 1'b0;
         step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic set_pix(input logic [3:0] tm, input logic [3:0] obj,
                          input logic valid, input logic trans);
      tm_pix    = tm;
      obj_pix   = obj;
      obj_valid = valid;
      obj_trans = trans;
   endtask

   initial begin
      rst = 1'b1; pcen = 1'b1; hblank = 1'b0; vblank = 1'b0;
      cmd_wr = 1'b0; cmd = 2'd0; cmd_arg = 4'd0;
      set_pix(4'h0, 4'h0, 1'b0, 1'b0);
      step();
      step();
      // Reset state
      check_val("rst_pixel", 8'(pixel), 8'h0);
      check_val("rst_fade",  8'(fade_level), 8'h0);
      check_val("rst_busy",  8'(busy), 8'h0);
      check_val("rst_bld",   8'({bld_tmen, bld_outen, bld_fw, bld_mode}), 8'h0);
      rst = 1'b0;

      // Translucent add with overflow clamp
      set_pix(4'h9, 4'h8, 1'b1, 1'b1);
      step();
      check_val("add_mode",  8'(bld_mode), 8'h0);
      check_val("add_tm",    8'(bld_tm), 8'h9);
      check_val("add_op",    8'(bld_obj), 8'h8);
      check_val("add_en",    8'({bld_tmen, bld_outen}), 8'h3);
      step();
      check_val("add_pixel", 8'(pixel), 8'hF);

      // Fade to D=5, then stop
      send_cmd(2'd1, 4'd0);
      frames(10);
      send_cmd(2'd0, 4'd0);
      check_val("d5_level", 8'(fade_level), 8'h5);
      check_val("d5_busy",  8'(busy), 8'h0);
      set_pix(4'h3, 4'h0, 1'b0, 1'b0);
      step();
      check_val("sub_op",   8'(bld_obj), 8'hA);
      check_val("sub_mode", 8'(bld_mode), 8'h1);
      step();
      check_val("sub_borrow", 8'(pixel), 8'h0);
      set_pix(4'hC, 4'h0, 1'b0, 1'b0);
      step(); step();
      check_val("sub_c", 8'(pixel), 8'h7);
      set_pix(4'h0, 4'hC, 1'b1, 1'b0);
      step(); step();
      check_val("sub_opaque_obj", 8'(pixel), 8'h7);

      // Full fade-out from 0 and back
      do_reset();
      send_cmd(2'd1, 4'd0);
      check_val("fo_busy_start", 8'(busy), 8'h1);
      frames(29);
      check_val("fo_29_level", 8'(fade_level), 8'hE);
      check_val("fo_29_busy",  8'(busy), 8'h1);
      frames(1);
      check_val("fo_30_level", 8'(fade_level), 8'hF);
      check_val("fo_30_busy",  8'(busy), 8'h0);
      send_cmd(2'd1, 4'd0);
      check_val("fo_at15_busy", 8'(busy), 8'h1);
      frames(1);
      check_val("fo_at15_idle",  8'(busy), 8'h0);
      check_val("fo_at15_level", 8'(fade_level), 8'hF);
      send_cmd(2'd2, 4'd0);
      frames(1);
      check_val("fi_1_level", 8'(fade_level), 8'hF);
      frames(1);
      check_val("fi_2_level", 8'(fade_level), 8'hE);
      frames(28);
      check_val("fi_30_level", 8'(fade_level), 8'h0);
      check_val("fi_30_busy",  8'(busy), 8'h0);

      // Flash with ARG=0 lasts 16 frames
      send_cmd(2'd3, 4'd0);
      check_val("fl_busy", 8'(busy), 8'h1);
      set_pix(4'h3, 4'h0, 1'b0, 1'b0);
      step(); step();
      check_val("fl_white", 8'(pixel), 8'hF);
      hblank = 1'b1;
      step(); step();
      check_val("fl_blank", 8'(pixel), 8'h0);
      hblank = 1'b0;
      frames(15);
      check_val("fl_15_busy",  8'(busy), 8'h1);
      check_val("fl_15_level", 8'(fade_level), 8'h0);
      frames(1);
      check_val("fl_16_busy", 8'(busy), 8'h0);
      step(); step();
      check_val("fl_after_pixel", 8'(pixel), 8'h3);

      // Command coincident with a frame tick
      do_reset();
      send_cmd(2'd1, 4'd0);
      frames(14);
      check_val("co_d7", 8'(fade_level), 8'h7);
      vblank = 1'b1;
      send_cmd(2'd2, 4'd0);
      vblank = 1'b0;
      step();
      check_val("co_level", 8'(fade_level), 8'h7);
      check_val("co_busy",  8'(busy), 8'h1);
      frames(1);
      check_val("co_fi_1", 8'(fade_level), 8'h7);
      frames(1);
      check_val("co_fi_2", 8'(fade_level), 8'h6);

      // Reset mid fade-out, then PCEN hold
      do_reset();
      send_cmd(2'd1, 4'd0);
      frames(18);
      check_val("rm_d9", 8'(fade_level), 8'h9);
      set_pix(4'hC, 4'h0, 1'b0, 1'b0);
      step(); step();
      check_val("rm_pix_pre", 8'(pixel), 8'h3);
      rst = 1'b1;
      step();
      check_val("rm_level", 8'(fade_level), 8'h0);
      check_val("rm_busy",  8'(busy), 8'h0);
      check_val("rm_pixel", 8'(pixel), 8'h0);
      check_val("rm_bld",   8'({bld_tm, bld_tmen, bld_outen, bld_mode}), 8'h0);
      rst = 1'b0;
      set_pix(4'h3, 4'h0, 1'b0, 1'b0);
      step(); step();
      check_val("hold_pre", 8'(pixel), 8'h3);
      pcen = 1'b0;
      set_pix(4'hC, 4'h0, 1'b0, 1'b0);
      step(); step(); step();
      check_val("hold_pixel", 8'(pixel), 8'h3);
      check_val("hold_tm",    8'(bld_tm), 8'h3);
      pcen = 1'b1;
      step(); step();
      check_val("hold_release", 8'(pixel), 8'hC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
